mem_axi_master: RTL

MEM_AXI_MASTER -- requirements
Module: mem_axi_master

---
 rtl/mem_axi_master_if.sv | 89 ++++++++
 rtl/mem_axi_master.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mem_axi_master_if.sv
// AXI4 bus bundle shared by the memory-to-AXI bridge and its slave side.
// Master drives AW/W/AR and the B/R readies; Slave drives the rest.
interface AXI_BUS #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ID_WIDTH   = 6,
  parameter int unsigned AXI_USER_WIDTH = 1
);
  localparam int unsigned STRB_WIDTH = AXI_DATA_WIDTH / 8;

  logic [AXI_ID_WIDTH-1:0]   aw_id;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]                aw_len;
  logic [2:0]                aw_size;
  logic [1:0]                aw_burst;
  logic                      aw_lock;
  logic [3:0]                aw_cache;
  logic [2:0]                aw_prot;
  logic [3:0]                aw_region;
  logic [3:0]                aw_qos;
  logic [AXI_USER_WIDTH-1:0] aw_user;
  logic                      aw_valid;
  logic                      aw_ready;

  logic [AXI_DATA_WIDTH-1:0] w_data;
  logic [STRB_WIDTH-1:0]     w_strb;
  logic                      w_last;
  logic [AXI_USER_WIDTH-1:0] w_user;
  logic                      w_valid;
  logic                      w_ready;

  logic [AXI_ID_WIDTH-1:0]   b_id;
  logic [1:0]                b_resp;
  logic [AXI_USER_WIDTH-1:0] b_user;
  logic                      b_valid;
  logic                      b_ready;

  logic [AXI_ID_WIDTH-1:0]   ar_id;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]                ar_len;
  logic [2:0]                ar_size;
  logic [1:0]                ar_burst;
  logic                      ar_lock;
  logic [3:0]                ar_cache;
  logic [2:0]                ar_prot;
  logic [3:0]                ar_region;
  logic [3:0]                ar_qos;
  logic [AXI_USER_WIDTH-1:0] ar_user;
  logic                      ar_valid;
  logic                      ar_ready;

  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [AXI_DATA_WIDTH-1:0] r_data;
  logic [1:0]                r_resp;
  logic                      r_last;
  logic [AXI_USER_WIDTH-1:0] r_user;
  logic                      r_valid;
  logic                      r_ready;

  modport Master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
           aw_prot, aw_region, aw_qos, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
           ar_prot, ar_region, ar_qos, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport Slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
           aw_prot, aw_region, aw_qos, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
           ar_prot, ar_region, ar_qos, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/mem_axi_master.sv
// Core memory request port to single-beat AXI4 master bridge.
// One transaction in flight; completion is a one-cycle rvalid_o pulse.
module mem_axi_master #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned AXI_ID_WIDTH   = 6,
    parameter int unsigned AXI_USER_WIDTH = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_i,
    output logic                        gnt_o,
    input  logic [AXI_ADDR_WIDTH-1:0]   addr_i,
    input  logic                        we_i,
    input  logic [AXI_DATA_WIDTH/8-1:0] be_i,
    input  logic [AXI_DATA_WIDTH-1:0]   wdata_i,
    output logic                        rvalid_o,
    output logic [AXI_DATA_WIDTH-1:0]   rdata_o,
    output logic                        err_o,
    AXI_BUS.Master                      master
);

    localparam int unsigned STRB_WIDTH = AXI_DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WAIT_B,
        READ,
        WAIT_R
    } state_e;

    state_e state_q, state_d;

    logic [AXI_ADDR_WIDTH-1:0] addr_q;
    logic                      we_q;
    logic [STRB_WIDTH-1:0]     be_q;
    logic [AXI_DATA_WIDTH-1:0] wdata_q;

    logic aw_pend_q, w_pend_q, ar_pend_q;
    logic gnt, b_ready, r_ready;
    logic aw_fin, w_fin, b_hs, r_hs;

    // A channel counts as finished if its handshake already happened or happens now.
    assign aw_fin = !aw_pend_q || master.aw_ready;
    assign w_fin  = !w_pend_q  || master.w_ready;
    assign b_hs   = b_ready && master.b_valid;
    assign r_hs   = r_ready && master.r_valid;

    always_comb begin
        state_d = state_q;
        gnt     = 1'b0;
        b_ready = 1'b0;
        r_ready = 1'b0;
        case (state_q)
            IDLE: begin
                // Gated by rst so no grant is reported while the state register is being cleared.
                if (req_i && !rst) begin
                    gnt     = 1'b1;
                    state_d = we_i ? WRITE : READ;
                end
            end
            WRITE: begin
                if (aw_fin && w_fin) state_d = WAIT_B;
            end
            WAIT_B: begin
                b_ready = 1'b1;
                if (master.b_valid) state_d = IDLE;
            end
            READ: begin
                if (master.ar_ready) state_d = WAIT_R;
            end
            WAIT_R: begin
                r_ready = 1'b1;
                if (master.r_valid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
            ar_pend_q <= 1'b0;
        end else if (gnt) begin
            aw_pend_q <= we_i;
            w_pend_q  <= we_i;
            ar_pend_q <= !we_i;
        end else begin
            if (aw_pend_q && master.aw_ready) aw_pend_q <= 1'b0;
            if (w_pend_q  && master.w_ready)  w_pend_q  <= 1'b0;
            if (ar_pend_q && master.ar_ready) ar_pend_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
        end else if (gnt) begin
            addr_q  <= {addr_i[AXI_ADDR_WIDTH-1:2], 2'b00};
            we_q    <= we_i;
            be_q    <= be_i;
            wdata_q <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_o <= 1'b0;
            err_o    <= 1'b0;
            rdata_o  <= '0;
        end else begin
            rvalid_o <= b_hs || r_hs;
            if (b_hs) err_o <= master.b_resp[1];
            if (r_hs) begin
                err_o   <= master.r_resp[1];
                rdata_o <= master.r_data;
            end
        end
    end

    assign gnt_o = gnt;

    assign master.aw_id     = '0;
    assign master.aw_addr   = addr_q;
    assign master.aw_len    = '0;
    assign master.aw_size   = 3'b010;
    assign master.aw_burst  = 2'b01;
    assign master.aw_lock   = 1'b0;
    assign master.aw_cache  = '0;
    assign master.aw_prot   = '0;
    assign master.aw_region = '0;
    assign master.aw_qos    = '0;
    assign master.aw_user   = '0;
    assign master.aw_valid  = aw_pend_q;

    assign master.w_data    = wdata_q;
    assign master.w_strb    = be_q;
    assign master.w_last    = 1'b1;
    assign master.w_user    = '0;
    assign master.w_valid   = w_pend_q;

    assign master.b_ready   = b_ready;

    assign master.ar_id     = '0;
    assign master.ar_addr   = addr_q;
    assign master.ar_len    = '0;
    assign master.ar_size   = 3'b010;
    assign master.ar_burst  = 2'b01;
    assign master.ar_lock   = 1'b0;
    assign master.ar_cache  = '0;
    assign master.ar_prot   = '0;
    assign master.ar_region = '0;
    assign master.ar_qos    = '0;
    assign master.ar_user   = '0;
    assign master.ar_valid  = ar_pend_q;

    assign master.r_ready   = r_ready;

    logic unused_sigs;
    assign unused_sigs = ^{we_q, master.b_id, master.b_user, master.b_resp[0],
                           master.r_id, master.r_user, master.r_last, master.r_resp[0]};

endmodule
